// File: rtl/usb_pkg.sv
// Shared encodings and phase lengths for the USB transmit scheduler.
package usb_pkg;

  localparam logic [1:0] SEL_TOKEN  = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b11;
  localparam logic [1:0] SEL_HSHAKE = 2'b10;

  localparam int unsigned SYNC_LEN = 8;
  localparam int unsigned EOP_LEN  = 3;

  // Grant vector bit positions, gnt = {hs, data, tok}
  localparam int unsigned GNT_TOK  = 0;
  localparam int unsigned GNT_DATA = 1;
  localparam int unsigned GNT_HS   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_PAYLOAD,
    ST_EOP
  } tx_state_t;

endpackage

// File: rtl/tx_bit_counter.sv
// Phase bit counter with synchronous clear and a terminal-count compare.
module tx_bit_counter #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_tc_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_tc_c = (cnt == tc);

endmodule

// File: rtl/usb_tx_sched.sv
// Transmit packet scheduler: arbitrates token/data/handshake requests and sequences
// LOAD, SYNC, PAYLOAD and EOP phases, driving PISO controls and line-phase flags.
module usb_tx_sched
  import usb_pkg::*;
#(
  parameter int unsigned TOK_BITS = 24,
  parameter int unsigned HS_BITS  = 8,
  parameter int unsigned DATA_MIN = 24,
  parameter int unsigned DATA_MAX = 536,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_req,
  input  logic             data_req,
  input  logic             hs_req,
  input  logic [CNT_W-1:0] data_len,
  input  logic             abort,
  output logic [1:0]       sel,
  output logic             ld_tok,
  output logic             ld_data,
  output logic             ld_hs,
  output logic             shift,
  output logic             piso_clr,
  output logic             sync_phase,
  output logic             sync_bit,
  output logic             eop_se0,
  output logic             busy,
  output logic [2:0]       gnt,
  output logic             done
);

  if (CNT_W < $clog2(DATA_MAX)) begin : g_cnt_w_check
    $error("usb_tx_sched: CNT_W too narrow for DATA_MAX");
  end

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] len, len_nxt;
  logic [CNT_W-1:0] cnt, tc;
  logic             at_tc_c, cnt_clr, cnt_en;
  logic [2:0]       gnt_nxt;
  logic [1:0]       sel_nxt;
  logic             ld_tok_nxt, ld_data_nxt, ld_hs_nxt, shift_nxt, piso_clr_nxt;
  logic             sync_phase_nxt, sync_bit_nxt, eop_se0_nxt, busy_nxt, done_nxt;

  tx_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .tc      (tc),
    .cnt     (cnt),
    .at_tc_c (at_tc_c)
  );

  // Terminal count depends only on the current phase, kept apart to avoid a comb loop
  always_comb begin
    tc = '0;
    unique case (state)
      ST_SYNC:    tc = CNT_W'(SYNC_LEN - 1);
      ST_PAYLOAD: tc = len - CNT_W'(1);
      ST_EOP:     tc = CNT_W'(EOP_LEN - 1);
      default:    tc = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    len_nxt   = len;
    unique case (state)
      ST_IDLE: begin
        if (hs_req || tok_req || data_req) begin
          state_nxt = ST_LOAD;
          if (hs_req) begin
            gnt_nxt = 3'b100;
            sel_nxt = SEL_HSHAKE;
            len_nxt = CNT_W'(HS_BITS);
          end else if (tok_req) begin
            gnt_nxt = 3'b001;
            sel_nxt = SEL_TOKEN;
            len_nxt = CNT_W'(TOK_BITS);
          end else begin
            gnt_nxt = 3'b010;
            sel_nxt = SEL_DATA;
            if (data_len < CNT_W'(DATA_MIN))      len_nxt = CNT_W'(DATA_MIN);
            else if (data_len > CNT_W'(DATA_MAX)) len_nxt = CNT_W'(DATA_MAX);
            else                                  len_nxt = data_len;
          end
        end
      end
      ST_LOAD:    state_nxt = ST_SYNC;
      ST_SYNC:    if (at_tc_c) state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: if (at_tc_c) state_nxt = ST_EOP;
      ST_EOP: begin
        if (at_tc_c) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      gnt_nxt   = '0;
    end

    // Counter restarts at every phase boundary so each phase counts from zero
    cnt_clr = (state_nxt != state) || (state == ST_IDLE) || (state == ST_LOAD);
    cnt_en  = !cnt_clr;

    ld_tok_nxt     = (state_nxt == ST_LOAD) && gnt_nxt[GNT_TOK];
    ld_data_nxt    = (state_nxt == ST_LOAD) && gnt_nxt[GNT_DATA];
    ld_hs_nxt      = (state_nxt == ST_LOAD) && gnt_nxt[GNT_HS];
    shift_nxt      = (state_nxt == ST_PAYLOAD);
    piso_clr_nxt   = abort && (state != ST_IDLE);
    sync_phase_nxt = (state_nxt == ST_SYNC);
    sync_bit_nxt   = (state == ST_SYNC) && (state_nxt == ST_SYNC) &&
                     (cnt == CNT_W'(SYNC_LEN - 2));
    eop_se0_nxt    = (state_nxt == ST_EOP) &&
                     !((state == ST_EOP) && (cnt == CNT_W'(EOP_LEN - 2)));
    done_nxt       = (state == ST_EOP) && (state_nxt == ST_EOP) &&
                     (cnt == CNT_W'(EOP_LEN - 2));
    busy_nxt       = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      len        <= '0;
      gnt        <= '0;
      sel        <= SEL_TOKEN;
      ld_tok     <= 1'b0;
      ld_data    <= 1'b0;
      ld_hs      <= 1'b0;
      shift      <= 1'b0;
      piso_clr   <= 1'b0;
      sync_phase <= 1'b0;
      sync_bit   <= 1'b0;
      eop_se0    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      len        <= len_nxt;
      gnt        <= gnt_nxt;
      sel        <= sel_nxt;
      ld_tok     <= ld_tok_nxt;
      ld_data    <= ld_data_nxt;
      ld_hs      <= ld_hs_nxt;
      shift      <= shift_nxt;
      piso_clr   <= piso_clr_nxt;
      sync_phase <= sync_phase_nxt;
      sync_bit   <= sync_bit_nxt;
      eop_se0    <= eop_se0_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Self-checking bench for usb_tx_sched: per-packet expected waveform derived from the
// grant cycle offset, packet length and fixed-priority arbitration of pending requests.
module tb_usb_tx_sched;

  localparam int unsigned CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst, tok_req, data_req, hs_req, abort;
  logic [CNT_W-1:0] data_len;
  logic [1:0]       sel;
  logic             ld_tok, ld_data, ld_hs, shift, piso_clr;
  logic             sync_phase, sync_bit, eop_se0, busy, done;
  logic [2:0]       gnt;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] pending;   // {hs, data, tok} requests currently held high
  logic [1:0] last_sel;
  logic       clr_next;

  usb_tx_sched dut (
    .clk        (clk),
    .rst        (rst),
    .tok_req    (tok_req),
    .data_req   (data_req),
    .hs_req     (hs_req),
    .data_len   (data_len),
    .abort      (abort),
    .sel        (sel),
    .ld_tok     (ld_tok),
    .ld_data    (ld_data),
    .ld_hs      (ld_hs),
    .shift      (shift),
    .piso_clr   (piso_clr),
    .sync_phase (sync_phase),
    .sync_bit   (sync_bit),
    .eop_se0    (eop_se0),
    .busy       (busy),
    .gnt        (gnt),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Vector layout: {sel, ld_tok, ld_data, ld_hs, shift, piso_clr, sync_phase,
  //                 sync_bit, eop_se0, busy, gnt, done}
  function automatic logic [14:0] idle_vec(input logic [1:0] s, input logic clr);
    return {s, 4'b0000, clr, 4'b0000, 3'b000, 1'b0};
  endfunction

  // k = cycles since the IDLE cycle in which the request was granted
  function automatic logic [14:0] pkt_vec(input int k, input int len,
                                          input logic [2:0] g, input logic [1:0] s);
    logic [14:0] v;
    v        = '0;
    v[14:13] = s;
    v[12]    = (k == 1) && g[0];
    v[11]    = (k == 1) && g[1];
    v[10]    = (k == 1) && g[2];
    v[9]     = (k >= 10) && (k <= 9 + len);
    v[7]     = (k >= 2) && (k <= 9);
    v[6]     = (k == 9);
    v[5]     = (k == 10 + len) || (k == 11 + len);
    v[4]     = 1'b1;
    v[3:1]   = g;
    v[0]     = (k == 12 + len);
    return v;
  endfunction

  task automatic check(input string tag, input int k, input logic [14:0] e);
    logic [14:0] o;
    o = {sel, ld_tok, ld_data, ld_hs, shift, piso_clr, sync_phase,
         sync_bit, eop_se0, busy, gnt, done};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, o, e);
    end
  endtask

  task automatic drive_reqs();
    {hs_req, data_req, tok_req} = pending;
  endtask

  task automatic step_idle(input string tag, input logic ab);
    @(negedge clk);
    check(tag, 0, idle_vec(last_sel, clr_next));
    clr_next = 1'b0;
    abort    = ab;
  endtask

  // One packet from its grant cycle; optional abort, async reset, or late request
  task automatic do_packet(input string tag, input logic [2:0] newr, input int dlen,
                           input int abort_at, input int rst_at,
                           input int late_at, input logic [2:0] late_r);
    logic [2:0] g;
    logic [1:0] s;
    int         len;
    int         last;
    @(negedge clk);
    check({tag, "/idle"}, 0, idle_vec(last_sel, clr_next));
    clr_next = 1'b0;
    abort    = 1'b0;
    pending  = pending | newr;
    if (pending == 3'b000) pending = 3'b001;
    if (dlen < 0) data_len = CNT_W'($urandom_range(0, 1023));
    else          data_len = CNT_W'(dlen);
    drive_reqs();
    if (pending[2]) begin
      g = 3'b100; s = 2'b10; len = 8;
    end else if (pending[0]) begin
      g = 3'b001; s = 2'b01; len = 24;
    end else begin
      g = 3'b010; s = 2'b11; len = int'(data_len);
      if (len < 24)  len = 24;
      if (len > 536) len = 536;
    end
    last_sel = s;
    last     = 12 + len;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        rst     = 1'b1;
        pending = '0;
        drive_reqs();
        #1;
        check({tag, "/rst"}, k, idle_vec(2'b01, 1'b0));
        last_sel = 2'b01;
        @(negedge clk);
        check({tag, "/rst_hold"}, k + 1, idle_vec(2'b01, 1'b0));
        rst = 1'b0;
        return;
      end
      check(tag, k, pkt_vec(k, len, g, s));
      if (k == late_at) begin
        pending = pending | late_r;
        drive_reqs();
      end
      if (k == abort_at) begin
        abort    = 1'b1;
        pending  = pending & ~g;
        drive_reqs();
        clr_next = 1'b1;
        return;
      end
      if (k == last) begin
        pending = pending & ~g;
        drive_reqs();
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    tok_req  = 1'b0;
    data_req = 1'b0;
    hs_req   = 1'b0;
    abort    = 1'b0;
    data_len = '0;
    pending  = '0;
    last_sel = 2'b01;
    clr_next = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", 0, idle_vec(2'b01, 1'b0));
    rst = 1'b0;
    step_idle("idle0", 1'b0);

    do_packet("hs_only", 3'b100, -1, -1, -1, -1, 3'b000);
    do_packet("tok_first", 3'b011, 100, -1, -1, -1, 3'b000);
    do_packet("data_second", 3'b000, 100, -1, -1, -1, 3'b000);
    step_idle("gap", 1'b1);
    step_idle("abort_in_idle", 1'b0);
    do_packet("data_len4", 3'b010, 4, -1, -1, -1, 3'b000);
    do_packet("data_len1000", 3'b010, 1000, -1, -1, -1, 3'b000);
    do_packet("tok_abort", 3'b001, -1, 20, -1, -1, 3'b000);
    step_idle("after_abort", 1'b0);
    do_packet("tok_rst_sync", 3'b001, -1, -1, 5, -1, 3'b000);
    do_packet("data_hs_late", 3'b010, 30, -1, -1, 15, 3'b100);
    do_packet("hs_after_data", 3'b000, -1, -1, -1, -1, 3'b000);

    for (int i = 0; i < 25; i++) begin
      logic [2:0] nr;
      int         ab;
      nr = 3'($urandom_range(0, 7));
      if (pending == 3'b000 && nr == 3'b000) nr = 3'b010;
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, 19));
      do_packet("rand", nr, -1, ab, -1, -1, 3'b000);
    end
    for (int i = 0; i < 3; i++) begin
      if (pending != 3'b000) do_packet("drain", 3'b000, -1, -1, -1, -1, 3'b000);
    end
    step_idle("end0", 1'b0);
    step_idle("end1", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
